// File: rtl/ctrl_pkg.sv
// Shared definitions for the processor control sequencer: phase encodings
// and default widths for the PC/breakpoint address and debug counters.
package ctrl_pkg;

   localparam int PHASE_W    = 3;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [PHASE_W-1:0] {
      ST_HALT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_e;

endpackage

// File: rtl/cpu_sequencer_retire_counter.sv
// Free-running wrap counter with enable; used for the retired-instruction
// count and suitable for other event/performance counters.
module retire_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count enabled events; wraps silently from all-ones to zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit processor. Steps each
// instruction through FETCH/DECODE/EXEC/(MEM)/WB, issuing one phase enable
// per cycle, and provides run/halt/single-step, one PC breakpoint and a
// retired-instruction counter for debug. All outputs are registered.
module cpu_sequencer
   import ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic               clk100,
   input  logic               rst_n,
   input  logic               run,
   input  logic               step,
   input  logic               halt_req,
   input  logic               bp_en,
   input  logic [ADDR_W-1:0]  bp_addr,
   input  logic [ADDR_W-1:0]  pc_addr,
   input  logic               is_load,
   output logic               ir_ce,
   output logic               dmem_re,
   output logic               reg_we,
   output logic               pc_ce,
   output logic               halted,
   output logic               bp_hit,
   output logic [PHASE_W-1:0] phase,
   output logic [CNT_W-1:0]   retired
);

   state_e r_state;
   state_e w_nxt;
   logic   r_ir_ce;
   logic   r_dmem_re;
   logic   r_wb;
   logic   r_halted;
   logic   r_bp_hit;
   logic   r_halt_pending;
   logic   r_step_mode;
   logic   r_bp_skip;
   logic   w_bp_match;
   logic   w_retire_en;

   // bp_skip suppresses the match on the first fetch after leaving HALT so
   // that execution can resume from the breakpoint PC itself.
   assign w_bp_match = bp_en && (pc_addr == bp_addr) && !r_bp_skip;

   // Next-phase selection from the registered phase and control inputs.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_HALT:   if (run || step) w_nxt = ST_FETCH;
         ST_FETCH:  w_nxt = w_bp_match ? ST_HALT : ST_DECODE;
         ST_DECODE: w_nxt = ST_EXEC;
         ST_EXEC:   w_nxt = is_load ? ST_MEM : ST_WB;
         ST_MEM:    w_nxt = ST_WB;
         ST_WB:     w_nxt = (r_halt_pending || r_step_mode || !run) ? ST_HALT : ST_FETCH;
         default:   w_nxt = ST_HALT;
      endcase
   end

   // Sequencer FSM: phase register, debug flags and phase enables registered
   // from the upcoming phase so each enable is high exactly in its phase.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_HALT;
         r_ir_ce        <= 1'b0;
         r_dmem_re      <= 1'b0;
         r_wb           <= 1'b0;
         r_halted       <= 1'b1;
         r_bp_hit       <= 1'b0;
         r_halt_pending <= 1'b0;
         r_step_mode    <= 1'b0;
         r_bp_skip      <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_ir_ce   <= (w_nxt == ST_FETCH);
         r_dmem_re <= (w_nxt == ST_MEM);
         r_wb      <= (w_nxt == ST_WB);
         r_halted  <= (w_nxt == ST_HALT);
         case (r_state)
            ST_HALT: begin
               // run has priority over step, so a combined press free-runs.
               if (run) begin
                  r_bp_skip <= 1'b1;
                  r_bp_hit  <= 1'b0;
               end else if (step) begin
                  r_step_mode <= 1'b1;
                  r_bp_skip   <= 1'b1;
                  r_bp_hit    <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (w_bp_match) begin
                  // Stopping here discards any pending stop request as well.
                  r_bp_hit       <= 1'b1;
                  r_halt_pending <= 1'b0;
                  r_step_mode    <= 1'b0;
               end else begin
                  r_bp_skip <= 1'b0;
                  if (halt_req) r_halt_pending <= 1'b1;
               end
            end
            ST_WB: begin
               if (w_nxt == ST_HALT) begin
                  r_halt_pending <= 1'b0;
                  r_step_mode    <= 1'b0;
               end else if (halt_req) begin
                  r_halt_pending <= 1'b1;
               end
            end
            default: begin
               if (halt_req) r_halt_pending <= 1'b1;
            end
         endcase
      end
   end

   assign w_retire_en = (r_state == ST_WB);

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .i_clk   (clk100),
      .i_rst_n (rst_n),
      .i_en    (w_retire_en),
      .o_count (retired)
   );

   assign ir_ce   = r_ir_ce;
   assign dmem_re = r_dmem_re;
   assign reg_we  = r_wb;
   assign pc_ce   = r_wb;
   assign halted  = r_halted;
   assign bp_hit  = r_bp_hit;
   assign phase   = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer. A 4-bit retired counter is used so
// the wrap case is reachable quickly. The bench advances pc_addr itself
// whenever the sequencer pulses pc_ce, standing in for the PC register.
module tb_cpu_sequencer;

   logic       clk100;
   logic       rst_n;
   logic       run;
   logic       step;
   logic       halt_req;
   logic       bp_en;
   logic [7:0] bp_addr;
   logic [7:0] pc_addr;
   logic       is_load;
   logic       ir_ce;
   logic       dmem_re;
   logic       reg_we;
   logic       pc_ce;
   logic       halted;
   logic       bp_hit;
   logic [2:0] phase;
   logic [3:0] retired;

   int n_vec = 0;
   int n_err = 0;
   int seq4[4] = '{1, 2, 3, 5};
   int seq5[5] = '{1, 2, 3, 4, 5};
   int cnt;
   int n;

   cpu_sequencer #(
      .ADDR_W (8),
      .CNT_W  (4)
   ) dut (
      .clk100   (clk100),
      .rst_n    (rst_n),
      .run      (run),
      .step     (step),
      .halt_req (halt_req),
      .bp_en    (bp_en),
      .bp_addr  (bp_addr),
      .pc_addr  (pc_addr),
      .is_load  (is_load),
      .ir_ce    (ir_ce),
      .dmem_re  (dmem_re),
      .reg_we   (reg_we),
      .pc_ce    (pc_ce),
      .halted   (halted),
      .bp_hit   (bp_hit),
      .phase    (phase),
      .retired  (retired)
   );

   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      logic pce;
      pce = pc_ce;
      @(posedge clk100);
      #1;
      if (pce) pc_addr = pc_addr + 8'd1;
   endtask

   initial begin
      run      = 1'b0;
      step     = 1'b0;
      halt_req = 1'b0;
      bp_en    = 1'b0;
      bp_addr  = 8'h00;
      pc_addr  = 8'h00;
      is_load  = 1'b0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_phase",   32'(phase),   0);
      chk("rst_halted",  32'(halted),  1);
      chk("rst_ir_ce",   32'(ir_ce),   0);
      chk("rst_dmem_re", 32'(dmem_re), 0);
      chk("rst_reg_we",  32'(reg_we),  0);
      chk("rst_pc_ce",   32'(pc_ce),   0);
      chk("rst_bp_hit",  32'(bp_hit),  0);
      chk("rst_retired", 32'(retired), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_halted", 32'(halted), 1);

      // 1: free-run, non-load instructions
      run = 1'b1;
      tick();
      chk("t1_ir_ce", 32'(ir_ce), 1);
      for (int i = 0; i < 12; i++) begin
         chk("t1_phase", 32'(phase), seq4[i % 4]);
         chk("t1_pc_ce", 32'(pc_ce), (seq4[i % 4] == 5) ? 1 : 0);
         chk("t1_ir_ce_only_fetch", 32'(ir_ce), (seq4[i % 4] == 1) ? 1 : 0);
         tick();
      end
      chk("t1_retired", 32'(retired), 3);
      chk("t1_phase12", 32'(phase), 1);
      run = 1'b0;
      repeat (4) tick();
      chk("t1_stop_halted",  32'(halted),  1);
      chk("t1_stop_retired", 32'(retired), 4);

      // 2: free-run, load instructions
      is_load = 1'b1;
      run     = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("t2_phase",   32'(phase),   seq5[i % 5]);
         chk("t2_dmem_re", 32'(dmem_re), (seq5[i % 5] == 4) ? 1 : 0);
         chk("t2_reg_we",  32'(reg_we),  (seq5[i % 5] == 5) ? 1 : 0);
         tick();
      end
      run = 1'b0;
      repeat (5) tick();
      chk("t2_halted",  32'(halted),  1);
      chk("t2_retired", 32'(retired), 7);

      // 3: single-step from HALT, twice
      is_load = 1'b0;
      for (int s = 0; s < 2; s++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         chk("t3_fetch", 32'(phase), 1);
         cnt = 0;
         for (int k = 0; k < 8; k++) begin
            if (pc_ce) cnt++;
            tick();
         end
         chk("t3_pulses",  cnt,            1);
         chk("t3_halted",  32'(halted),    1);
         chk("t3_retired", 32'(retired),   8 + s);
      end

      // 4: breakpoint at 0x05, then step past it
      pc_addr = 8'h03;
      bp_en   = 1'b1;
      bp_addr = 8'h05;
      run     = 1'b1;
      tick();
      chk("t4_start_fetch", 32'(phase), 1);
      n = 0;
      while (!halted && n < 40) begin
         tick();
         n++;
      end
      chk("t4_bp_halted",  32'(halted),  1);
      chk("t4_bp_hit",     32'(bp_hit),  1);
      chk("t4_bp_ir_ce",   32'(ir_ce),   0);
      chk("t4_bp_pc",      32'(pc_addr), 5);
      chk("t4_bp_retired", 32'(retired), 11);
      run  = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("t4_step_fetch",  32'(phase),  1);
      chk("t4_step_ir_ce",  32'(ir_ce),  1);
      chk("t4_bp_hit_clr",  32'(bp_hit), 0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (pc_ce) cnt++;
         tick();
      end
      chk("t4_step_pulses",  cnt,            1);
      chk("t4_step_halted",  32'(halted),    1);
      chk("t4_step_retired", 32'(retired),   12);
      chk("t4_step_pc",      32'(pc_addr),   6);
      chk("t4_step_bp_hit",  32'(bp_hit),    0);

      // 5: halt request during DECODE, then reset during EXEC
      bp_en = 1'b0;
      run   = 1'b1;
      tick();
      tick();
      chk("t5_decode", 32'(phase), 2);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("t5_exec", 32'(phase), 3);
      tick();
      chk("t5_wb",        32'(phase),  5);
      chk("t5_wb_reg_we", 32'(reg_we), 1);
      tick();
      chk("t5_halted",  32'(halted),  1);
      chk("t5_retired", 32'(retired), 13);
      tick();
      tick();
      tick();
      chk("t5_exec2", 32'(phase), 3);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_phase",   32'(phase),   0);
      chk("t5_rst_halted",  32'(halted),  1);
      chk("t5_rst_ir_ce",   32'(ir_ce),   0);
      chk("t5_rst_dmem_re", 32'(dmem_re), 0);
      chk("t5_rst_reg_we",  32'(reg_we),  0);
      chk("t5_rst_pc_ce",   32'(pc_ce),   0);
      chk("t5_rst_retired", 32'(retired), 0);
      run = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // 6: halt_req ignored in HALT; run+step free-runs; counter wraps
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("t6_idle_halted", 32'(halted), 1);
      run  = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("t6_fetch", 32'(phase), 1);
      repeat (60) tick();
      chk("t6_freerun_phase",  32'(phase),   1);
      chk("t6_freerun_halted", 32'(halted),  0);
      chk("t6_retired15",      32'(retired), 15);
      repeat (4) tick();
      chk("t6_wrap_retired", 32'(retired), 0);
      chk("t6_wrap_phase",   32'(phase),   1);
      run = 1'b0;
      repeat (4) tick();
      chk("t6_final_halted", 32'(halted), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
